pc_redirect_unit: RTL
=====================

Name: pc_redirect_unit

Overview:
- Parametrised next-PC generator for the fetch front end. It owns the architectural fetch PC register and arbitrates between sources for the next fetch address each cycle.
- Sources: reset vector, interrupt vector, branch-mispredict recovery from N integer channels, BTB prediction, and sequential fetch-block increment.
- It buffers a redirect that arrives while fetch is stalled and applies it when the stall releases. It drives the I-cache next-read address and a one-cycle history-recovery pulse.
- Sits between the branch resolution write-back ports and the fetch stage.

Parameters:
- PC_WIDTH, 32, fetch address width in bits.
- FETCH_WIDTH, 2, instructions per fetch block; power of two.
- INSN_BYTES, 4, bytes per instruction; power of two.
- BR_CHANNELS, 2, number of branch-result channels; channel 0 is oldest in program order.
- HIST_WIDTH, 10, global branch-history width.
- RESET_VECTOR, 32'h0000_1000, PC loaded at start.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- rst_start  in  1  one-cycle pulse; begin fetch from RESET_VECTOR
- stall  in  1  fetch stage cannot accept a new PC this cycle
- int_we  in  1  interrupt redirect request
- int_addr  in  PC_WIDTH  interrupt handler address
- br_valid  in  BR_CHANNELS  branch result valid per channel
- br_mispred  in  BR_CHANNELS  result was mispredicted
- br_target  in  BR_CHANNELS*PC_WIDTH  correct next PC per channel
- br_hist  in  BR_CHANNELS*HIST_WIDTH  checkpointed history per channel
- pred_valid  in  1  BTB hit with taken prediction for current block
- pred_target  in  PC_WIDTH  predicted target
- pc_out  out  PC_WIDTH  current fetch PC
- pc_valid  out  1  pc_out is a live fetch address
- ic_next_addr  out  PC_WIDTH  address the I-cache reads next cycle
- recover_hist  out  1  one-cycle history-recovery pulse
- recovered_hist  out  HIST_WIDTH  history to restore
- flush  out  1  in-flight fetch blocks must be squashed

Behaviour:
- States: IDLE, RUN, HOLD. Reset enters IDLE. Reset values: pc_out=RESET_VECTOR, pc_valid=0, recover_hist=0, recovered_hist=0, flush=0, pending buffer empty.
- IDLE -> RUN on rst_start. pc_out=RESET_VECTOR and pc_valid=1 in the following cycle. All other inputs are ignored in IDLE.
- Block size B=FETCH_WIDTH*INSN_BYTES.
  - Sequential next = (pc_out & ~(B-1)) + B, computed modulo 2^PC_WIDTH so wrap to 0 is legal.
- Selection priority, highest first, combinational:
  1. int_we: next = int_addr.
  2. Lowest-index channel with br_valid&br_mispred: next = that br_target.
  3. Pending buffer.
  4. pred_valid: next = pred_target.
  5. Sequential.
- flush is combinational and is 1 whenever the winning source is interrupt, mispredict, or pending.
- RUN, stall=0: pc_out <= next at the clock edge. ic_next_addr = next, zero latency.
- RUN, stall=1: pc_out holds and ic_next_addr = pc_out.
  - If an interrupt or mispredict arrives, it is written to the pending buffer and the state moves to HOLD.
  - pred_valid is ignored while stalled.
- HOLD: pc_out holds and ic_next_addr = pc_out.
  - A new interrupt overwrites the pending entry unconditionally.
  - A new mispredict overwrites it only if the pending entry is not an interrupt.
  - On stall=0: pc_out <= pending target (or a higher-priority same-cycle source), the buffer clears, and the state returns to RUN.
- recover_hist=1 for exactly one cycle, the cycle after a mispredict channel wins selection or is buffered. recovered_hist = that channel's br_hist. Same-cycle interrupt suppresses the pulse.
- Multiple mispredicts in one cycle: only the lowest index is used; the others are dropped.
- Asynchronous reset mid-operation returns to IDLE and clears the buffer within the same cycle.
- rst_start while in RUN or HOLD: restart at RESET_VECTOR and clear the buffer.

Optional Feature:
- PC_REDIRECT_STATS_EN defined: adds four 32-bit saturating counters (int, mispredict, predicted-taken, stall-buffered), readable on output stat_cnt[4*32] and cleared by reset.
- Undefined: no counters and no stat_cnt port.

Decomposition:
- Shared package pc_redirect_types:
  - state enum {IDLE, RUN, HOLD}
  - redirect source enum {SRC_NONE, SRC_INT, SRC_BR, SRC_PEND, SRC_PRED, SRC_SEQ}
  - pending-entry struct {valid, is_int, target, hist, has_hist}
- Sub-module pc_redirect_arbiter: combinational lowest-index mispredict picker plus priority mux, returning source and target.

Test Plan:
- Reset, then rst_start, then 3 idle cycles with FETCH_WIDTH=2, INSN_BYTES=4 -> pc_out 0x1000, 0x1008, 0x1010, 0x1018; pc_valid=1 from the cycle after rst_start.
- pc_out=0x1004, pred_valid with target 0x2000 -> next pc_out 0x2000, flush=0. Sequential from 0x1004 gives 0x1008 (aligned).
- Same cycle: br_valid=2'b11, br_mispred=2'b11, targets 0x3000/0x4000, hist 0x055/0x0AA -> pc_out 0x3000, flush=1, recover_hist pulses one cycle later with 0x055.
- stall=1, mispredict to 0x5000, then 2 cycles later int_we to 0x0100, stall drops -> pc_out 0x0100, single recover_hist pulse from the mispredict only.
- pc_out=0xFFFF_FFF8 sequential -> 0x0000_0000.
- Async reset asserted in HOLD with a pending entry -> IDLE immediately, pc_valid=0; after rst_start fetch resumes at 0x1000 and the pending target is never issued.

Source files
------------

// File: rtl/pc_redirect_unit_pkg.sv
// rtl/pc_redirect_unit_pkg.sv - shared types for the fetch next-PC redirect unit
package pc_redirect_types;

    localparam int unsigned PEND_PC_W   = 32;
    localparam int unsigned PEND_HIST_W = 10;
    localparam int unsigned STAT_W      = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD
    } state_e;

    typedef enum logic [2:0] {
        SRC_NONE,
        SRC_INT,
        SRC_BR,
        SRC_PEND,
        SRC_PRED,
        SRC_SEQ
    } redirect_src_e;

    // Redirect captured while fetch was stalled; has_hist marks a mispredict entry.
    typedef struct packed {
        logic                   valid;
        logic                   is_int;
        logic [PEND_PC_W-1:0]   target;
        logic [PEND_HIST_W-1:0] hist;
        logic                   has_hist;
    } pend_entry_t;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + STAT_W'(1) : v;
    endfunction

endpackage

// File: rtl/pc_redirect_arbiter.sv
// rtl/pc_redirect_arbiter.sv - lowest-index mispredict picker and next-PC priority mux
module pc_redirect_arbiter
    import pc_redirect_types::*;
#(
    parameter int PC_WIDTH    = 32,
    parameter int BR_CHANNELS = 2,
    parameter int HIST_WIDTH  = 10
) (
    input  logic                            int_we,
    input  logic [PC_WIDTH-1:0]             int_addr,
    input  logic [BR_CHANNELS-1:0]          br_valid,
    input  logic [BR_CHANNELS-1:0]          br_mispred,
    input  logic [BR_CHANNELS*PC_WIDTH-1:0] br_target,
    input  logic [BR_CHANNELS*HIST_WIDTH-1:0] br_hist,
    input  pend_entry_t                     pend,
    input  logic                            pred_valid,
    input  logic [PC_WIDTH-1:0]             pred_target,
    input  logic [PC_WIDTH-1:0]             seq_target,
    output redirect_src_e                   src,
    output logic [PC_WIDTH-1:0]             target,
    output logic [HIST_WIDTH-1:0]           hist
);

    logic                  br_hit;
    logic [PC_WIDTH-1:0]   br_sel_target;
    logic [HIST_WIDTH-1:0] br_sel_hist;

    // Scan from the top so the lowest (oldest) channel is the last writer.
    always_comb begin
        br_hit        = 1'b0;
        br_sel_target = '0;
        br_sel_hist   = '0;
        for (int i = BR_CHANNELS - 1; i >= 0; i--) begin
            if (br_valid[i] && br_mispred[i]) begin
                br_hit        = 1'b1;
                br_sel_target = br_target[i*PC_WIDTH +: PC_WIDTH];
                br_sel_hist   = br_hist[i*HIST_WIDTH +: HIST_WIDTH];
            end
        end
    end

    always_comb begin
        src    = SRC_SEQ;
        target = seq_target;
        hist   = '0;
        if (int_we) begin
            src    = SRC_INT;
            target = int_addr;
        end else if (br_hit) begin
            src    = SRC_BR;
            target = br_sel_target;
            hist   = br_sel_hist;
        end else if (pend.valid) begin
            src    = SRC_PEND;
            target = PC_WIDTH'(pend.target);
            hist   = pend.has_hist ? HIST_WIDTH'(pend.hist) : '0;
        end else if (pred_valid) begin
            src    = SRC_PRED;
            target = pred_target;
        end
    end

endmodule

// File: rtl/pc_redirect_unit.sv
// rtl/pc_redirect_unit.sv - fetch PC register and next-PC arbitration; PC_REDIRECT_STATS_EN adds stat_cnt counters
module pc_redirect_unit
    import pc_redirect_types::*;
#(
    parameter int                  PC_WIDTH     = 32,
    parameter int                  FETCH_WIDTH  = 2,
    parameter int                  INSN_BYTES   = 4,
    parameter int                  BR_CHANNELS  = 2,
    parameter int                  HIST_WIDTH   = 10,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = 32'h0000_1000
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              rst_start,
    input  logic                              stall,
    input  logic                              int_we,
    input  logic [PC_WIDTH-1:0]               int_addr,
    input  logic [BR_CHANNELS-1:0]            br_valid,
    input  logic [BR_CHANNELS-1:0]            br_mispred,
    input  logic [BR_CHANNELS*PC_WIDTH-1:0]   br_target,
    input  logic [BR_CHANNELS*HIST_WIDTH-1:0] br_hist,
    input  logic                              pred_valid,
    input  logic [PC_WIDTH-1:0]               pred_target,
    output logic [PC_WIDTH-1:0]               pc_out,
    output logic                              pc_valid,
    output logic [PC_WIDTH-1:0]               ic_next_addr,
    output logic                              recover_hist,
    output logic [HIST_WIDTH-1:0]             recovered_hist,
    output logic                              flush
`ifdef PC_REDIRECT_STATS_EN
    ,
    output logic [4*STAT_W-1:0]               stat_cnt
`endif
);

    localparam logic [PC_WIDTH-1:0] BLOCK_BYTES = PC_WIDTH'(FETCH_WIDTH * INSN_BYTES);

    state_e                state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic                  pc_valid_q, pc_valid_d;
    pend_entry_t           pend_q, pend_d;
    logic                  recover_q, recover_d;
    logic [HIST_WIDTH-1:0] rec_hist_q, rec_hist_d;

    logic [PC_WIDTH-1:0]    seq_target;
    logic [BR_CHANNELS-1:0] arb_br_valid;
    logic                   arb_pred_valid;
    redirect_src_e          arb_src;
    logic [PC_WIDTH-1:0]    arb_target;
    logic [HIST_WIDTH-1:0]  arb_hist;

    assign seq_target = (pc_q & ~(BLOCK_BYTES - PC_WIDTH'(1))) + BLOCK_BYTES;

    // A buffered interrupt is never displaced by a later mispredict.
    assign arb_br_valid   = br_valid & ~{BR_CHANNELS{pend_q.valid & pend_q.is_int}};
    assign arb_pred_valid = pred_valid & ~stall;

    pc_redirect_arbiter #(
        .PC_WIDTH    (PC_WIDTH),
        .BR_CHANNELS (BR_CHANNELS),
        .HIST_WIDTH  (HIST_WIDTH)
    ) u_arbiter (
        .int_we      (int_we),
        .int_addr    (int_addr),
        .br_valid    (arb_br_valid),
        .br_mispred  (br_mispred),
        .br_target   (br_target),
        .br_hist     (br_hist),
        .pend        (pend_q),
        .pred_valid  (arb_pred_valid),
        .pred_target (pred_target),
        .seq_target  (seq_target),
        .src         (arb_src),
        .target      (arb_target),
        .hist        (arb_hist)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pc_valid_d   = pc_valid_q;
        pend_d       = pend_q;
        recover_d    = 1'b0;
        rec_hist_d   = rec_hist_q;
        ic_next_addr = pc_q;
        flush        = 1'b0;
        case (state_q)
            IDLE: begin
                if (rst_start) begin
                    state_d      = RUN;
                    pc_d         = RESET_VECTOR;
                    pc_valid_d   = 1'b1;
                    pend_d       = '0;
                    ic_next_addr = RESET_VECTOR;
                end
            end
            default: begin
                if (rst_start) begin
                    state_d      = RUN;
                    pc_d         = RESET_VECTOR;
                    pend_d       = '0;
                    ic_next_addr = RESET_VECTOR;
                    flush        = 1'b1;
                end else begin
                    flush = (arb_src == SRC_INT) || (arb_src == SRC_BR) || (arb_src == SRC_PEND);
                    if (arb_src == SRC_BR) begin
                        recover_d  = 1'b1;
                        rec_hist_d = arb_hist;
                    end
                    if (!stall) begin
                        state_d      = RUN;
                        pc_d         = arb_target;
                        pend_d       = '0;
                        ic_next_addr = arb_target;
                    end else if ((arb_src == SRC_INT) || (arb_src == SRC_BR)) begin
                        state_d         = HOLD;
                        pend_d.valid    = 1'b1;
                        pend_d.is_int   = (arb_src == SRC_INT);
                        pend_d.target   = PEND_PC_W'(arb_target);
                        pend_d.hist     = PEND_HIST_W'(arb_hist);
                        pend_d.has_hist = (arb_src == SRC_BR);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_VECTOR;
            pc_valid_q <= 1'b0;
            pend_q     <= '0;
            recover_q  <= 1'b0;
            rec_hist_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_valid_q <= pc_valid_d;
            pend_q     <= pend_d;
            recover_q  <= recover_d;
            rec_hist_q <= rec_hist_d;
        end
    end

    assign pc_out         = pc_q;
    assign pc_valid       = pc_valid_q;
    assign recover_hist   = recover_q;
    assign recovered_hist = rec_hist_q;

`ifdef PC_REDIRECT_STATS_EN
    logic              stat_active;
    logic [STAT_W-1:0] cnt_int_q, cnt_int_d;
    logic [STAT_W-1:0] cnt_br_q, cnt_br_d;
    logic [STAT_W-1:0] cnt_pred_q, cnt_pred_d;
    logic [STAT_W-1:0] cnt_buf_q, cnt_buf_d;

    assign stat_active = (state_q != IDLE) && !rst_start;

    always_comb begin
        cnt_int_d  = sat_inc(cnt_int_q, stat_active && (arb_src == SRC_INT));
        cnt_br_d   = sat_inc(cnt_br_q, stat_active && (arb_src == SRC_BR));
        cnt_pred_d = sat_inc(cnt_pred_q, stat_active && (arb_src == SRC_PRED));
        cnt_buf_d  = sat_inc(cnt_buf_q, stat_active && stall &&
                             ((arb_src == SRC_INT) || (arb_src == SRC_BR)));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_int_q  <= '0;
            cnt_br_q   <= '0;
            cnt_pred_q <= '0;
            cnt_buf_q  <= '0;
        end else begin
            cnt_int_q  <= cnt_int_d;
            cnt_br_q   <= cnt_br_d;
            cnt_pred_q <= cnt_pred_d;
            cnt_buf_q  <= cnt_buf_d;
        end
    end

    assign stat_cnt = {cnt_buf_q, cnt_pred_q, cnt_br_q, cnt_int_q};
`endif

endmodule
